// File: rtl/tmds_decode.sv
// TMDS receive channel: bit-slip alignment on control-token runs, then 10b->8b decode.
// One instance per channel, running on the pixel clock.
module tmds_decode #(
   parameter int LOCK_RUN       = 16,
   parameter int SEARCH_TIMEOUT = 1024,
   parameter int LOSS_TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] din,
   output logic [7:0] dout,
   output logic       de,
   output logic       c0,
   output logic       c1,
   output logic       locked,
   output logic [3:0] offset
);
   localparam int RUN_W = $clog2(LOCK_RUN + 1);
   localparam int TMR_W = $clog2(SEARCH_TIMEOUT);
   localparam int GAP_W = $clog2(LOSS_TIMEOUT);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           state, state_n;
   logic [3:0]       offset_n;
   logic [RUN_W-1:0] ctl_run, ctl_run_n, run_inc;
   logic [TMR_W-1:0] tmr, tmr_n;
   logic [GAP_W-1:0] gap, gap_n;

   logic [9:0]  prev, sym;
   logic [19:0] win;
   logic        is_ctl;
   logic [1:0]  ctl_code;
   logic [7:0]  d, dec;
   logic [7:0]  dout_r;
   logic        de_r;
   logic [1:0]  c_r;

   // prev holds the older word, so a symbol straddling two words is read low-to-high
   assign win = {din, prev};

   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= '0;
         sym  <= '0;
      end else begin
         prev <= din;
         sym  <= win[offset +: 10];
      end
   end

   always_comb begin
      is_ctl   = 1'b0;
      ctl_code = 2'b00;
      case (sym)
         10'h354: begin is_ctl = 1'b1; ctl_code = 2'b00; end
         10'h0AB: begin is_ctl = 1'b1; ctl_code = 2'b01; end
         10'h154: begin is_ctl = 1'b1; ctl_code = 2'b10; end
         10'h2AB: begin is_ctl = 1'b1; ctl_code = 2'b11; end
         default: ;
      endcase
   end

   // sym[9] marks inverted payload, sym[8] selects XOR vs XNOR chaining
   always_comb begin
      d      = sym[9] ? ~sym[7:0] : sym[7:0];
      dec    = '0;
      dec[0] = d[0];
      for (int i = 1; i < 8; i++)
         dec[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_r <= '0;
         de_r   <= 1'b0;
         c_r    <= 2'b00;
      end else if (is_ctl) begin
         de_r <= 1'b0;
         c_r  <= ctl_code;
      end else begin
         de_r   <= 1'b1;
         dout_r <= dec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= SEARCH;
         offset  <= '0;
         ctl_run <= '0;
         tmr     <= '0;
         gap     <= '0;
      end else begin
         state   <= state_n;
         offset  <= offset_n;
         ctl_run <= ctl_run_n;
         tmr     <= tmr_n;
         gap     <= gap_n;
      end
   end

   always_comb begin
      state_n   = state;
      offset_n  = offset;
      ctl_run_n = ctl_run;
      tmr_n     = tmr;
      gap_n     = gap;
      run_inc   = '0;
      case (state)
         SEARCH: begin
            if (is_ctl)
               run_inc = (ctl_run == RUN_W'(LOCK_RUN)) ? ctl_run : ctl_run + RUN_W'(1);
            // a completed run beats a simultaneous timeout, so the offset stays put
            if (is_ctl && run_inc == RUN_W'(LOCK_RUN)) begin
               state_n   = LOCKED;
               ctl_run_n = '0;
               tmr_n     = '0;
               gap_n     = '0;
            end else if (tmr == TMR_W'(SEARCH_TIMEOUT - 1)) begin
               offset_n  = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
               tmr_n     = '0;
               ctl_run_n = '0;
            end else begin
               tmr_n     = tmr + TMR_W'(1);
               ctl_run_n = run_inc;
            end
         end
         LOCKED: begin
            if (is_ctl)
               gap_n = '0;
            else if (gap == GAP_W'(LOSS_TIMEOUT - 1)) begin
               state_n   = SEARCH;
               gap_n     = '0;
               tmr_n     = '0;
               ctl_run_n = '0;
            end else
               gap_n = gap + GAP_W'(1);
         end
         default: state_n = SEARCH;
      endcase
   end

   assign locked = (state == LOCKED);
   assign dout   = locked ? dout_r : '0;
   assign de     = locked & de_r;
   assign c0     = locked & c_r[0];
   assign c1     = locked & c_r[1];
endmodule

// File: tb/tb_tmds_decode.sv
// Directed bench for tmds_decode: table-driven decode vectors plus alignment/lock sequences.
module tb_tmds_decode;
   localparam logic [9:0] CTL0 = 10'h354;
   localparam logic [9:0] CTL1 = 10'h0AB;
   localparam logic [9:0] CTL2 = 10'h154;
   localparam logic [9:0] CTL3 = 10'h2AB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] din = '0;
   logic [7:0] dout;
   logic       de, c0, c1, locked;
   logic [3:0] offset;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [9:0] din;
      logic [7:0] dout;
      logic       de;
      logic [1:0] c;
   } vec_t;
   vec_t tbl[11];

   logic [9:0] sk_prev = '0;
   int         sk_idx  = 0;

   tmds_decode dut (
      .clk(clk), .rst(rst), .din(din), .dout(dout), .de(de),
      .c0(c0), .c1(c1), .locked(locked), .offset(offset)
   );

   always #5 clk = ~clk;

   task automatic tick(input logic [9:0] w);
      din = w;
      @(posedge clk);
      #1;
   endtask

   // serialize alternating CTL1/CTL2 with each symbol starting at bit 'skew' of a word
   task automatic skew_tick(input int skew);
      logic [9:0]  s;
      logic [19:0] t;
      s = sk_idx[0] ? CTL2 : CTL1;
      t = {s, sk_prev} >> (10 - skew);
      sk_prev = s;
      sk_idx++;
      tick(t[9:0]);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick(CTL0);
      rst = 1'b0;
      sk_prev = '0;
      sk_idx  = 0;
   endtask

   initial begin
      logic [1:0] last_c;
      int         lock_at;

      tbl[0]  = '{10'h100, 8'h00, 1'b1, 2'b00};
      tbl[1]  = '{10'h200, 8'hFF, 1'b1, 2'b00};
      tbl[2]  = '{CTL3,    8'hFF, 1'b0, 2'b11};
      tbl[3]  = '{CTL1,    8'hFF, 1'b0, 2'b01};
      tbl[4]  = '{10'h1FF, 8'h01, 1'b1, 2'b01};
      tbl[5]  = '{CTL2,    8'h01, 1'b0, 2'b10};
      tbl[6]  = '{CTL0,    8'h01, 1'b0, 2'b00};
      tbl[7]  = '{10'h3C3, 8'h44, 1'b1, 2'b00};
      tbl[8]  = '{10'h0F0, 8'hEE, 1'b1, 2'b00};
      tbl[9]  = '{CTL0,    8'hEE, 1'b0, 2'b00};
      tbl[10] = '{CTL0,    8'hEE, 1'b0, 2'b00};

      // reset with CTL0 present, then lock on a continuous CTL0 stream
      do_reset(3);
      chk("rst_outs", {dout, de, c1, c0}, 11'h0);
      chk("rst_locked", locked, 0);
      chk("rst_offset", offset, 0);
      repeat (17) tick(CTL0);
      chk("lock0_early", locked, 0);
      tick(CTL0);
      chk("lock0", locked, 1);
      chk("lock0_offset", offset, 0);
      chk("lock0_ctl", {de, c1, c0}, 3'b000);

      // decode table: word i shows up after the tick of word i+2
      for (int i = 0; i < 11; i++) begin
         tick(tbl[i].din);
         if (i >= 2)
            chk($sformatf("dec%0d", i - 2), {dout, de, c1, c0},
                {tbl[i-2].dout, tbl[i-2].de, tbl[i-2].c});
      end

      // loss of lock after LOSS_TIMEOUT data symbols, then relock at same offset
      repeat (4096) tick(10'h200);
      tick(CTL0);
      chk("loss_hold", {locked, de, dout}, {1'b1, 1'b1, 8'hFF});
      tick(CTL0);
      chk("loss_drop", locked, 0);
      chk("loss_forced", {dout, de, c1, c0}, 11'h0);
      repeat (15) tick(CTL0);
      chk("relock_early", locked, 0);
      tick(CTL0);
      chk("relock", locked, 1);
      chk("relock_offset", offset, 0);
      chk("relock_outs", {dout, de, c1, c0}, {8'hFF, 3'b000});

      // near miss: 15 tokens, one data symbol, then a fresh run
      do_reset(1);
      for (int n = 1; n <= 34; n++) begin
         tick(n == 16 ? 10'h100 : CTL0);
         if (n == 33) chk("nearmiss_nolock", locked, 0);
         if (n == 34) chk("nearmiss_lock", locked, 1);
      end

      // 3-bit skew: offset walks 0..3 then locks
      do_reset(1);
      last_c = 2'b00;
      for (int n = 1; n <= 3092; n++) begin
         skew_tick(3);
         case (n)
            1023: chk("skew_off0", offset, 0);
            1024: chk("skew_off1", offset, 1);
            2047: chk("skew_off1_hold", offset, 1);
            2048: chk("skew_off2", offset, 2);
            3072: chk("skew_off3", offset, 3);
            3088: chk("skew_nolock", locked, 0);
            3089: begin
               chk("skew_lock", locked, 1);
               chk("skew_lock_off", offset, 3);
               chk("skew_alt0", ({c1, c0} == 2'b01) || ({c1, c0} == 2'b10), 1);
               last_c = {c1, c0};
            end
            default: if (n > 3089) begin
               chk($sformatf("skew_alt%0d", n - 3089), {de, c1, c0}, {1'b0, last_c ^ 2'b11});
               last_c = {c1, c0};
            end
         endcase
      end

      // 5-bit skew lock, then a single-cycle reset while locked
      do_reset(1);
      lock_at = 0;
      for (int n = 1; n <= 6000 && lock_at == 0; n++) begin
         skew_tick(5);
         if (locked) lock_at = n;
      end
      chk("skew5_lock_cycle", lock_at, 5137);
      chk("skew5_offset", offset, 5);
      repeat (3) skew_tick(5);
      rst = 1'b1;
      tick(CTL1);
      rst = 1'b0;
      chk("midrst_state", {locked, offset}, 5'h0);
      chk("midrst_outs", {dout, de, c1, c0}, 11'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
